// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned PHASES  = 17;
  localparam int unsigned PHASE_W = 5;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_RSUB = 3'd4,
    OP_SLT  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] ctrl;
    logic       sub;
    logic       stl;
    logic       cin;
  } ctrl_word_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode into the ALU static control word.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  output ctrl_word_t cw,
  output logic       illegal
);

  // Unused opcodes fall back to the AND word and are flagged.
  always_comb begin
    cw      = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  cw = '0;
      OP_OR:   cw.ctrl = 2'b01;
      OP_ADD:  cw.ctrl = 2'b10;
      OP_SUB: begin
        cw.ctrl = 2'b10;
        cw.stl  = 1'b1;
        cw.cin  = 1'b1;
      end
      OP_RSUB: begin
        cw.ctrl = 2'b10;
        cw.sub  = 1'b1;
        cw.cin  = 1'b1;
      end
      OP_SLT: begin
        cw.ctrl = 2'b11;
        cw.stl  = 1'b1;
        cw.cin  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU request, holds its control word across the datapath phases,
// then captures and presents the result over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PHASES = 17
) (
  input  logic             clkpos,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_asel,
  input  logic             req_bsel,
  input  logic [1:0]       req_osel,
  output logic             ALU_Control1,
  output logic             ALU_Control0,
  output logic             SUB,
  output logic             STL,
  output logic             Adder_Cin,
  output logic             B_mux0,
  output logic             B_mux1,
  output logic             A_mux,
  output logic             mux3_0,
  output logic             mux3_1,
  output logic [4:0]       phase,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic             zero_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  import alu_seq_pkg::*;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  state_e     state;
  ctrl_word_t cw_q;
  ctrl_word_t dec_cw;
  logic       dec_illegal;
  logic       err_q;
  logic [1:0] asel_q;
  logic       bsel_q;
  logic [1:0] osel_q;

  alu_op_decode u_decode (
    .op      (req_op),
    .cw      (dec_cw),
    .illegal (dec_illegal)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      phase     <= '0;
      cw_q      <= '0;
      err_q     <= 1'b0;
      asel_q    <= '0;
      bsel_q    <= 1'b0;
      osel_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ST_RUN;
            req_ready <= 1'b0;
            phase     <= '0;
            cw_q      <= dec_cw;
            err_q     <= dec_illegal;
            asel_q    <= req_asel;
            bsel_q    <= req_bsel;
            osel_q    <= req_osel;
          end
        end
        ST_RUN: begin
          if (phase == LAST_PHASE) begin
            state     <= ST_RESP;
            phase     <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result_in;
            rsp_zero  <= zero_in;
            rsp_err   <= err_q;
          end else begin
            phase <= PHASE_W'(phase + 5'd1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ALU_Control1 = cw_q.ctrl[1];
  assign ALU_Control0 = cw_q.ctrl[0];
  assign SUB          = cw_q.sub;
  assign STL          = cw_q.stl;
  assign Adder_Cin    = cw_q.cin;
  assign B_mux1       = asel_q[1];
  assign B_mux0       = asel_q[0];
  assign A_mux        = bsel_q;
  assign mux3_1       = osel_q[1];
  assign mux3_0       = osel_q[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;

  logic        clkpos;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_asel;
  logic        req_bsel;
  logic [1:0]  req_osel;
  logic        ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin;
  logic        B_mux0, B_mux1, A_mux, mux3_0, mux3_1;
  logic [4:0]  phase;
  logic [15:0] alu_result_in;
  logic        zero_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(16), .PHASES(17)) dut (
    .clkpos        (clkpos),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_asel      (req_asel),
    .req_bsel      (req_bsel),
    .req_osel      (req_osel),
    .ALU_Control1  (ALU_Control1),
    .ALU_Control0  (ALU_Control0),
    .SUB           (SUB),
    .STL           (STL),
    .Adder_Cin     (Adder_Cin),
    .B_mux0        (B_mux0),
    .B_mux1        (B_mux1),
    .A_mux         (A_mux),
    .mux3_0        (mux3_0),
    .mux3_1        (mux3_1),
    .phase         (phase),
    .alu_result_in (alu_result_in),
    .zero_in       (zero_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_zero      (rsp_zero),
    .rsp_err       (rsp_err)
  );

  initial clkpos = 1'b0;
  always #5 clkpos = ~clkpos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {Ctrl1, Ctrl0, SUB, STL, Cin}
  function automatic logic [4:0] cw_bus();
    return {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin};
  endfunction

  // {B_mux1, B_mux0, A_mux, mux3_1, mux3_0}
  function automatic logic [4:0] sel_bus();
    return {B_mux1, B_mux0, A_mux, mux3_1, mux3_0};
  endfunction

  task automatic tick();
    @(posedge clkpos);
    #1;
  endtask

  // Issue one request, walk all phases, collect the response after hold_cycles of back-pressure.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] asel,
                        input logic bsel, input logic [1:0] osel,
                        input logic [15:0] result, input logic zero,
                        input logic [4:0] exp_cw, input logic exp_err,
                        input int hold_cycles, input bit keep_valid, input logic [2:0] other_op);
    logic [4:0] exp_sel;
    exp_sel = {asel, bsel, osel};
    req_op = op; req_asel = asel; req_bsel = bsel; req_osel = osel;
    req_valid = 1'b1;
    alu_result_in = ~result;
    zero_in = ~zero;
    check_eq({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    tick();
    if (keep_valid) begin
      req_op = other_op; req_asel = ~asel; req_bsel = ~bsel; req_osel = ~osel;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        alu_result_in = result;
        zero_in = zero;
      end
      check_eq({tag, "_phase"}, 32'(phase), 32'(i));
      check_eq({tag, "_cw"}, 32'(cw_bus()), 32'(exp_cw));
      check_eq({tag, "_sel"}, 32'(sel_bus()), 32'(exp_sel));
      check_eq({tag, "_busy"}, 32'({req_ready, rsp_valid}), 32'd0);
      tick();
      alu_result_in = 16'hDEAD;
      zero_in = ~zero;
    end
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'(result));
    check_eq({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(zero));
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check_eq({tag, "_cw_resp"}, 32'(cw_bus()), 32'(exp_cw));
    for (int k = 0; k < hold_cycles; k++) begin
      tick();
      check_eq({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_stall_data"}, 32'(rsp_data), 32'(result));
      check_eq({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  int extra_rsp;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_asel = '0; req_bsel = 1'b0; req_osel = '0;
    alu_result_in = '0; zero_in = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_cw", 32'(cw_bus()), 32'd0);
    check_eq("rst_sel", 32'(sel_bus()), 32'd0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_zero, rsp_err}), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);

    run_op("sub", 3'd3, 2'b11, 1'b1, 2'b01, 16'h0000, 1'b1, 5'b10011, 1'b0, 0, 1'b0, 3'd0);
    run_op("add", 3'd2, 2'b01, 1'b0, 2'b10, 16'h1234, 1'b0, 5'b10000, 1'b0, 10, 1'b0, 3'd0);
    run_op("ill7", 3'd7, 2'b00, 1'b0, 2'b00, 16'h00F0, 1'b0, 5'b00000, 1'b1, 0, 1'b0, 3'd0);
    run_op("rsub", 3'd4, 2'b10, 1'b1, 2'b11, 16'hFFFF, 1'b0, 5'b10101, 1'b0, 2, 1'b0, 3'd0);

    // Reset at phase 8 of an SLT.
    req_op = 3'd5; req_asel = 2'b10; req_bsel = 1'b1; req_osel = 2'b11; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_eq("slt_cw", 32'(cw_bus()), 32'b11011);
    repeat (8) tick();
    check_eq("slt_phase8", 32'(phase), 32'd8);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_phase", 32'(phase), 32'd0);
    check_eq("midrst_cw", 32'(cw_bus()), 32'd0);
    check_eq("midrst_sel", 32'(sel_bus()), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clkpos);
    rst = 1'b0;
    extra_rsp = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (rsp_valid) extra_rsp++;
    end
    check_eq("midrst_no_rsp", 32'(extra_rsp), 32'd0);
    run_op("or", 3'd1, 2'b01, 1'b1, 2'b00, 16'hA5A5, 1'b0, 5'b01000, 1'b0, 0, 1'b0, 3'd0);

    // req_valid held through RUN/RESP with a different opcode.
    run_op("hold", 3'd2, 2'b00, 1'b0, 2'b01, 16'h0F0F, 1'b0, 5'b10000, 1'b0, 3, 1'b1, 3'd5);
    extra_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || !req_ready) extra_rsp++;
    end
    check_eq("hold_single_rsp", 32'(extra_rsp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
